// File: rtl/class_vote_pkg.sv
// Shared types, defaults and width helper for the class vote accumulator.
package class_vote_pkg;

  localparam int unsigned N_CLASSES_DEF = 6;
  localparam int unsigned MAX_TREES_DEF = 16;

  // Accumulate beats, scan counters for the argmax, present the result.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Width of an index/count field; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vote_counter_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module vote_counter_sat #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] max_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, else increment until the ceiling is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < max_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/class_vote_accum.sv
// Per-class vote accumulator with sequential argmax and valid/ready result port.
module class_vote_accum
  import class_vote_pkg::*;
#(
  parameter int unsigned N_CLASSES = N_CLASSES_DEF,
  parameter int unsigned MAX_TREES = MAX_TREES_DEF,
  parameter int unsigned CNT_W     = clog2_min1(MAX_TREES + 1),
  parameter int unsigned IDX_W     = clog2_min1(N_CLASSES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CLASSES-1:0] in_votes,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_class,
  output logic [CNT_W-1:0]     out_score,
  output logic                 out_novote,
  output logic                 out_ovf
);

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_class_q, out_class_d;
  logic [CNT_W-1:0] out_score_q, out_score_d;
  logic             out_novote_q, out_novote_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept_c;
  logic             clr_c;
  logic [CNT_W-1:0] sel_cnt_c;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_arr [N_CLASSES];

  // Reset synchronizer: asserts immediately, releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // One saturating vote counter per class.
  for (genvar k = 0; k < N_CLASSES; k++) begin : g_cnt
    vote_counter_sat #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_int_n),
      .clr_i (clr_c),
      .inc_i (accept_c & in_votes[k]),
      .max_i (CNT_W'(MAX_TREES)),
      .cnt_o (cnt_arr[k])
    );
  end

  // Beat counter stops one above the tree limit so overflow stays visible.
  vote_counter_sat #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_int_n),
    .clr_i (clr_c),
    .inc_i (accept_c),
    .max_i (CNT_W'(MAX_TREES + 1)),
    .cnt_o (beat_cnt)
  );

  // Select the counter currently being scanned.
  always_comb begin
    sel_cnt_c = '0;
    for (int k = 0; k < N_CLASSES; k++) begin
      if (scan_idx_q == IDX_W'(k)) begin
        sel_cnt_c = cnt_arr[k];
      end
    end
  end

  // Next-state, scan datapath and registered output values.
  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    best_idx_d   = best_idx_q;
    best_cnt_d   = best_cnt_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    out_novote_d = out_novote_q;
    out_ovf_d    = out_ovf_q;
    accept_c     = 1'b0;
    clr_c        = 1'b0;

    case (state_q)
      ACCUM: begin
        accept_c = in_valid;
        if (in_valid && in_last) begin
          state_d    = SCAN;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (sel_cnt_c > best_cnt_q) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = sel_cnt_c;
        end
        if (scan_idx_q == IDX_W'(N_CLASSES - 1)) begin
          state_d      = OUT;
          out_valid_d  = 1'b1;
          out_class_d  = best_idx_d;
          out_score_d  = best_cnt_d;
          out_novote_d = (best_cnt_d == '0);
          out_ovf_d    = (beat_cnt > CNT_W'(MAX_TREES));
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = ACCUM;
          clr_c       = 1'b1;
          out_valid_d = 1'b0;
          out_ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    in_ready_d = (state_d == ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= ACCUM;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_score_q  <= '0;
      out_novote_q <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      best_idx_q   <= best_idx_d;
      best_cnt_q   <= best_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
      out_novote_q <= out_novote_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_score  = out_score_q;
  assign out_novote = out_novote_q;
  assign out_ovf    = out_ovf_q;

endmodule
